// File: rtl/gat_pkg.sv
// Shared definitions for the GAT BRAM load controller: FSM states,
// error-cause codes and fixed channel indices.
package gat_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;  // word address beyond programmed length
  localparam logic [1:0] ERR_CHAN  = 2'd2;  // channel masked off or already complete
  localparam logic [1:0] ERR_IDX   = 2'd3;  // channel index does not exist

  localparam int unsigned CH_H_DATA    = 32'd0;
  localparam int unsigned CH_NODE_INFO = 32'd1;
  localparam int unsigned CH_WGT       = 32'd2;

  // Picks the reported cause when several apply: bad index beats range beats channel state.
  function automatic logic [1:0] err_prio(input logic idx_bad, input logic range_bad);
    logic [1:0] code;
    if (idx_bad) begin
      code = ERR_IDX;
    end else if (range_bad) begin
      code = ERR_RANGE;
    end else begin
      code = ERR_CHAN;
    end
    return code;
  endfunction

endpackage

// File: rtl/gat_load_ch_cnt.sv
// One BRAM load channel: holds the programmed length, counts accepted
// writes and flags completion when the count reaches the length.
module gat_load_ch_cnt
  import gat_pkg::*;
#(
  parameter int ADDR_W = 18,
  parameter int LEN_W  = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,     // layer start (already has priority over writes)
  input  logic              mask_i,      // this channel takes part in the new layer
  input  logic [LEN_W-1:0]  len_i,       // expected word count for the new layer
  input  logic              sel_i,       // live write in LOAD targeting this channel
  input  logic [ADDR_W-1:0] addr_i,      // word address of the write
  output logic              accept_o,
  output logic              in_range_o,
  output logic              open_o,      // masked in and not yet complete
  output logic              done_o
);

  logic              mask_q, mask_d;
  logic              done_q, done_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [LEN_W-1:0]  cnt_inc_s;
  logic              in_range_s;
  logic              open_s;
  logic              accept_s;

  // Accept decode and next-state for length, count and done flag.
  always_comb begin
    len_d      = len_q;
    cnt_d      = cnt_q;
    mask_d     = mask_q;
    done_d     = done_q;
    cnt_inc_s  = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
    in_range_s = ({1'b0, addr_i} < len_q);
    open_s     = mask_q & ~done_q;
    accept_s   = sel_i & open_s & in_range_s;
    if (start_i) begin
      mask_d = mask_i;
      if (mask_i) begin
        // A zero-length channel is complete as soon as the layer starts.
        len_d  = len_i;
        cnt_d  = {LEN_W{1'b0}};
        done_d = (len_i == {LEN_W{1'b0}});
      end else begin
        // Unmasked channels keep length, count and done from the previous layer.
        len_d  = len_q;
        cnt_d  = cnt_q;
        done_d = done_q;
      end
    end else if (accept_s) begin
      // Done rises together with the final write appearing on the BRAM port.
      cnt_d  = cnt_inc_s;
      done_d = (cnt_inc_s == len_q);
    end else begin
      cnt_d  = cnt_q;
      done_d = done_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q  <= {LEN_W{1'b0}};
      cnt_q  <= {LEN_W{1'b0}};
      mask_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
      done_q <= done_d;
    end
  end

  assign accept_o   = accept_s;
  assign in_range_o = in_range_s;
  assign open_o     = open_s;
  assign done_o     = done_q;

endmodule

// File: rtl/gat_bram_load_ctrl.sv
// Demultiplexes the PS byte-addressed write bus onto NUM_CH BRAM write
// ports, tracks per-channel completion, flags bad writes and issues a
// single start pulse to gat_top once every channel is loaded.
module gat_bram_load_ctrl
  import gat_pkg::*;
#(
  parameter int TOP_WIDTH = 32,
  parameter int NUM_CH    = 3,
  parameter int CH_SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int MAX_DEPTH = 242101,
  parameter int ADDR_W    = $clog2(MAX_DEPTH),
  parameter int LEN_W     = ADDR_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic [NUM_CH-1:0]       cfg_mask,
  input  logic [NUM_CH*LEN_W-1:0] cfg_len,
  input  logic                    wr_valid,
  input  logic [CH_SEL_W-1:0]     wr_ch,
  input  logic [ADDR_W+1:0]       wr_addr,
  input  logic [TOP_WIDTH-1:0]    wr_data,
  output logic [NUM_CH-1:0]       bram_we,
  output logic [ADDR_W-1:0]       bram_addr,
  output logic [TOP_WIDTH-1:0]    bram_din,
  output logic [NUM_CH-1:0]       load_done,
  output logic                    all_done,
  output logic                    gat_start,
  output logic                    busy,
  output logic                    err,
  output logic [1:0]              err_code
);

  state_e                state_q, state_d;
  logic [NUM_CH-1:0]     bram_we_q;
  logic [ADDR_W-1:0]     bram_addr_q;
  logic [TOP_WIDTH-1:0]  bram_din_q;
  logic                  all_done_q;
  logic                  gat_start_q;
  logic                  busy_q;
  logic                  err_q;
  logic [1:0]            err_code_q;

  logic [ADDR_W-1:0]     word_addr_s;
  logic                  wr_live_s;
  logic [NUM_CH-1:0]     sel_s;
  logic [NUM_CH-1:0]     accept_s;
  logic [NUM_CH-1:0]     in_range_s;
  logic [NUM_CH-1:0]     open_s;
  logic [NUM_CH-1:0]     done_s;
  logic                  idx_ok_s;
  logic                  range_ok_s;
  logic                  reject_s;
  logic                  unused_s;

  // Byte lane bits carry no information for word-wide BRAM writes.
  assign unused_s    = &{1'b0, wr_addr[1:0]};
  assign word_addr_s = wr_addr[ADDR_W+1:2];
  // A start in the same cycle drops any write without raising an error.
  assign wr_live_s   = (state_q == LOAD) & wr_valid & ~cfg_start;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign sel_s[c] = wr_live_s & (wr_ch == CH_SEL_W'(c));

    gat_load_ch_cnt #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .start_i    (cfg_start),
      .mask_i     (cfg_mask[c]),
      .len_i      (cfg_len[c*LEN_W +: LEN_W]),
      .sel_i      (sel_s[c]),
      .addr_i     (word_addr_s),
      .accept_o   (accept_s[c]),
      .in_range_o (in_range_s[c]),
      .open_o     (open_s[c]),
      .done_o     (done_s[c])
    );
  end

  // Range status of the addressed channel, and whether that channel exists.
  always_comb begin
    idx_ok_s   = 1'b0;
    range_ok_s = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      idx_ok_s   = (wr_ch == CH_SEL_W'(c)) ? 1'b1          : idx_ok_s;
      range_ok_s = (wr_ch == CH_SEL_W'(c)) ? in_range_s[c] : range_ok_s;
    end
    reject_s = wr_live_s & ~(|accept_s);
  end

  // Next-state logic: any start (re)enters LOAD, LOAD ends once all channels are done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cfg_start) state_d = LOAD;
        else           state_d = IDLE;
      end
      LOAD: begin
        if (cfg_start)      state_d = LOAD;
        else if (&done_s)   state_d = DONE;
        else                state_d = LOAD;
      end
      DONE: begin
        if (cfg_start) state_d = LOAD;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Registered BRAM port, completion flags and sticky error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      bram_we_q   <= {NUM_CH{1'b0}};
      bram_addr_q <= {ADDR_W{1'b0}};
      bram_din_q  <= {TOP_WIDTH{1'b0}};
      all_done_q  <= 1'b0;
      gat_start_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      bram_we_q <= accept_s;
      if (|accept_s) begin
        bram_addr_q <= word_addr_s;
        bram_din_q  <= wr_data;
      end
      all_done_q  <= &done_s;
      gat_start_q <= (&done_s) & ~all_done_q;
      busy_q      <= (state_d == LOAD);
      if (cfg_start) begin
        err_q      <= 1'b0;
        err_code_q <= ERR_NONE;
      end else if (reject_s && !err_q) begin
        err_q      <= 1'b1;
        err_code_q <= err_prio(~idx_ok_s, ~range_ok_s);
      end
    end
  end

  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;
  assign load_done = done_s;
  assign all_done  = all_done_q;
  assign gat_start = gat_start_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_gat_bram_load_ctrl.sv
// Directed bench for gat_bram_load_ctrl: basic load, range/channel errors,
// layer reload, start/write collision, burst and mid-load reset.
module tb_gat_bram_load_ctrl;

  localparam int TOP_WIDTH = 32;
  localparam int NUM_CH    = 3;
  localparam int CH_SEL_W  = 2;
  localparam int ADDR_W    = 18;
  localparam int LEN_W     = 19;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cfg_start;
  logic [NUM_CH-1:0]       cfg_mask;
  logic [NUM_CH*LEN_W-1:0] cfg_len;
  logic                    wr_valid;
  logic [CH_SEL_W-1:0]     wr_ch;
  logic [ADDR_W+1:0]       wr_addr;
  logic [TOP_WIDTH-1:0]    wr_data;
  logic [NUM_CH-1:0]       bram_we;
  logic [ADDR_W-1:0]       bram_addr;
  logic [TOP_WIDTH-1:0]    bram_din;
  logic [NUM_CH-1:0]       load_done;
  logic                    all_done;
  logic                    gat_start;
  logic                    busy;
  logic                    err;
  logic [1:0]              err_code;

  int checks = 0;
  int errors = 0;

  gat_bram_load_ctrl #(
    .TOP_WIDTH (TOP_WIDTH),
    .NUM_CH    (NUM_CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_mask  (cfg_mask),
    .cfg_len   (cfg_len),
    .wr_valid  (wr_valid),
    .wr_ch     (wr_ch),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .load_done (load_done),
    .all_done  (all_done),
    .gat_start (gat_start),
    .busy      (busy),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_CH*LEN_W-1:0] pack_len(input int l0, input int l1, input int l2);
    return {LEN_W'(l2), LEN_W'(l1), LEN_W'(l0)};
  endfunction

  task automatic start(input logic [2:0] mask, input logic [NUM_CH*LEN_W-1:0] len);
    cfg_start = 1'b1;
    cfg_mask  = mask;
    cfg_len   = len;
    wr_valid  = 1'b0;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wr(input int ch, input int byte_addr, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_ch    = CH_SEL_W'(ch);
    wr_addr  = (ADDR_W+2)'(byte_addr);
    wr_data  = d;
    tick();
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; cfg_start = 1'b0; cfg_mask = 3'b000; cfg_len = '0;
    wr_valid = 1'b0; wr_ch = 2'd0; wr_addr = 20'd0; wr_data = 32'd0;
    tick(); tick();
    chk("rst_we", 64'(bram_we), 64'd0);
    chk("rst_done", 64'(load_done), 64'd0);
    chk("rst_all", 64'(all_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_gs", 64'(gat_start), 64'd0);
    rst = 1'b0;

    // Writes in IDLE are dropped silently.
    wr(0, 32'h0, 32'h1111_1111);
    chk("idle_we", 64'(bram_we), 64'd0);
    chk("idle_err", 64'(err), 64'd0);

    // Basic load: len {ch0=2, ch1=3, ch2=4}.
    start(3'b111, pack_len(2, 3, 4));
    chk("b_busy", 64'(busy), 64'd1);
    chk("b_done0", 64'(load_done), 64'd0);
    wr(0, 32'h0, 32'hA000_0000);
    chk("b_we0", 64'(bram_we), 64'b001);
    chk("b_addr0", 64'(bram_addr), 64'd0);
    chk("b_din0", 64'(bram_din), 64'hA000_0000);
    wr(0, 32'h4, 32'hA000_0001);
    chk("b_addr1", 64'(bram_addr), 64'd1);
    chk("b_done_c0", 64'(load_done), 64'b001);
    for (int i = 0; i < 3; i++) begin
      wr(1, 4 * i, 32'hB000_0000 + 32'(i));
      chk("b_we_c1", 64'(bram_we), 64'b010);
      chk("b_addr_c1", 64'(bram_addr), 64'(i));
    end
    chk("b_done_c1", 64'(load_done), 64'b011);
    for (int i = 0; i < 4; i++) begin
      wr(2, 4 * i, 32'hC000_0000 + 32'(i));
      chk("b_we_c2", 64'(bram_we), 64'b100);
      chk("b_addr_c2", 64'(bram_addr), 64'(i));
    end
    chk("b_din_c2", 64'(bram_din), 64'hC000_0003);
    chk("b_done_all", 64'(load_done), 64'b111);
    chk("b_all_pre", 64'(all_done), 64'd0);
    chk("b_gs_pre", 64'(gat_start), 64'd0);
    idle();
    chk("b_all", 64'(all_done), 64'd1);
    chk("b_gs", 64'(gat_start), 64'd1);
    chk("b_we_idle", 64'(bram_we), 64'd0);
    idle();
    chk("b_gs_once", 64'(gat_start), 64'd0);
    chk("b_busy_done", 64'(busy), 64'd0);
    chk("b_err", 64'(err), 64'd0);

    // Layer-2 reload: weight channel only, len 2.
    start(3'b100, pack_len(7, 7, 2));
    chk("r_done", 64'(load_done), 64'b011);
    chk("r_all_lag", 64'(all_done), 64'd1);
    wr(2, 32'h0, 32'hD000_0000);
    chk("r_we0", 64'(bram_we), 64'b100);
    chk("r_all_drop", 64'(all_done), 64'd0);
    wr(2, 32'h4, 32'hD000_0001);
    chk("r_addr1", 64'(bram_addr), 64'd1);
    chk("r_done_full", 64'(load_done), 64'b111);
    idle();
    chk("r_gs", 64'(gat_start), 64'd1);

    // Out of range on ch2 (len 4), counter must not move.
    start(3'b100, pack_len(7, 7, 4));
    wr(2, 32'h10, 32'hE000_0000);
    chk("o_we", 64'(bram_we), 64'd0);
    chk("o_err", 64'(err), 64'd1);
    chk("o_code", 64'(err_code), 64'd1);
    wr(2, 32'h0, 32'hE000_0001);
    wr(2, 32'h4, 32'hE000_0002);
    wr(2, 32'h8, 32'hE000_0003);
    chk("o_cnt", 64'(load_done), 64'b011);
    wr(3, 32'h0, 32'hE000_0004);
    chk("o_we_bad", 64'(bram_we), 64'd0);
    chk("o_first", 64'(err_code), 64'd1);
    wr(2, 32'hC, 32'hE000_0005);
    chk("o_addr3", 64'(bram_addr), 64'd3);
    chk("o_done", 64'(load_done), 64'b111);
    idle(); idle();

    // Bad index, start/write collision, masked channel, burst of 5 on ch0.
    start(3'b011, pack_len(5, 0, 9));
    chk("m_done", 64'(load_done), 64'b110);
    chk("m_err_clr", 64'(err), 64'd0);
    wr(3, 32'h0, 32'hF000_0000);
    chk("m_err_idx", 64'(err), 64'd1);
    chk("m_code3", 64'(err_code), 64'd3);
    cfg_start = 1'b1; wr_valid = 1'b1; wr_ch = 2'd0; wr_addr = 20'd0;
    tick();
    cfg_start = 1'b0;
    chk("s_we", 64'(bram_we), 64'd0);
    chk("s_err", 64'(err), 64'd0);
    chk("s_done", 64'(load_done), 64'b110);
    wr(2, 32'h0, 32'hF000_0001);
    chk("m_we", 64'(bram_we), 64'd0);
    chk("m_code2", 64'(err_code), 64'd2);
    for (int i = 0; i < 5; i++) begin
      wr(0, 4 * i, 32'h5000_0000 + 32'(i));
      chk("burst_we", 64'(bram_we), 64'b001);
      chk("burst_addr", 64'(bram_addr), 64'(i));
      if (i == 3) chk("burst_mid", 64'(load_done), 64'b110);
    end
    chk("burst_done", 64'(load_done), 64'b111);
    idle();
    chk("burst_gs", 64'(gat_start), 64'd1);

    // Reset in the middle of a load.
    start(3'b001, pack_len(4, 9, 9));
    chk("x_done", 64'(load_done), 64'b110);
    wr(0, 32'h0, 32'h6000_0000);
    wr(0, 32'h4, 32'h6000_0001);
    wr(3, 32'h0, 32'h6000_0002);
    chk("x_err", 64'(err), 64'd1);
    rst = 1'b1; wr_valid = 1'b1; wr_ch = 2'd0; wr_addr = 20'h8;
    tick();
    rst = 1'b0; wr_valid = 1'b0;
    chk("x_we", 64'(bram_we), 64'd0);
    chk("x_addr", 64'(bram_addr), 64'd0);
    chk("x_din", 64'(bram_din), 64'd0);
    chk("x_ld", 64'(load_done), 64'd0);
    chk("x_busy", 64'(busy), 64'd0);
    chk("x_err0", 64'(err), 64'd0);
    chk("x_code", 64'(err_code), 64'd0);
    start(3'b111, pack_len(4, 0, 0));
    chk("y_done", 64'(load_done), 64'b110);
    for (int i = 0; i < 4; i++) begin
      wr(0, 4 * i, 32'h7000_0000 + 32'(i));
      chk("y_we", 64'(bram_we), 64'b001);
      if (i == 2) chk("y_mid", 64'(load_done), 64'b110);
    end
    chk("y_addr", 64'(bram_addr), 64'd3);
    chk("y_din", 64'(bram_din), 64'h7000_0003);
    chk("y_done_all", 64'(load_done), 64'b111);
    idle();
    chk("y_all", 64'(all_done), 64'd1);
    chk("y_gs", 64'(gat_start), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gat_bram_load_ctrl.md
Name: gat_bram_load_ctrl

Overview:
- Parametrised successor to the single-purpose BRAM load path in the GAT top wrapper.
- Accepts one shared PS-side byte-addressed 32-bit write bus and demultiplexes it into NUM_CH on-chip BRAM write ports (H data, H node_info, weight, plus spares).
- Per channel: converts byte to word addresses, truncates data to the channel width, counts accepted writes against a programmed length and raises a per-channel load_done.
- Replaces the PS-driven *_load_done bits with hardware completion detection, range checking, a per-layer channel mask and a one-cycle start pulse for gat_top.

Parameters:
- TOP_WIDTH, 32, PS data bus width.
- NUM_CH, 3, number of BRAM channels (0 = h_data, 1 = h_node_info, 2 = weight).
- CH_SEL_W, $clog2(NUM_CH) (minimum 1), channel select width.
- MAX_DEPTH, 242101, deepest channel in words.
- ADDR_W, $clog2(MAX_DEPTH), word address width.
- LEN_W, ADDR_W+1, programmed length width.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous active-high reset.
- cfg_start, input, 1, pulse: latch cfg_len/cfg_mask, clear counters, begin load.
- cfg_mask, input, NUM_CH, channels to load this layer; unmasked channels keep their prior done state.
- cfg_len, input, NUM_CH*LEN_W, packed expected word count per channel; channel c at [c*LEN_W +: LEN_W].
- wr_valid, input, 1, write strobe.
- wr_ch, input, CH_SEL_W, target channel.
- wr_addr, input, ADDR_W+2, byte address; bits [1:0] are ignored.
- wr_data, input, TOP_WIDTH, write data.
- bram_we, output, NUM_CH, one-hot write enable.
- bram_addr, output, ADDR_W, word address (shared bus).
- bram_din, output, TOP_WIDTH, write data (shared bus); each BRAM slices its own low bits.
- load_done, output, NUM_CH, per-channel sticky done.
- all_done, output, 1, high when every channel is done.
- gat_start, output, 1, one-cycle pulse on the all_done rising edge.
- busy, output, 1, high while state is LOAD.
- err, output, 1, sticky error flag.
- err_code, output, 2, first error cause: 1 = address out of range, 2 = channel masked or already done, 3 = channel index >= NUM_CH.

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-load):
  - bram_we = 0, bram_addr = 0, bram_din = 0.
  - load_done = 0, all_done = 0, gat_start = 0, busy = 0, err = 0, err_code = 0.
  - Counters = 0, state = IDLE.
- FSM states IDLE, LOAD, DONE:
  - IDLE -> LOAD on cfg_start.
  - LOAD -> DONE when every channel has load_done = 1.
  - DONE -> LOAD on cfg_start. This starts the next layer and clears load_done only for masked channels.
  - cfg_start in LOAD restarts the load: latch new config, clear counters and done bits for masked channels, clear err.
- cfg_start handling:
  - A channel with mask = 1 and len = 0 is done in the cycle after start.
  - A channel with mask = 0 keeps its existing load_done value.
- Write acceptance: a write is accepted only in LOAD, and only when all of the following hold:
  - wr_ch < NUM_CH
  - mask[wr_ch] = 1
  - load_done[wr_ch] = 0
  - wr_addr[ADDR_W+1:2] < len[wr_ch]
- Accepted write, one cycle later:
  - bram_we[wr_ch] = 1.
  - bram_addr = wr_addr[ADDR_W+1:2].
  - bram_din = wr_data.
  - The channel counter increments.
- Latency is exactly 1 cycle from wr_valid to bram_we; back-to-back writes sustain 1 per cycle.
- Completion: load_done[c] rises in the same cycle the write with count == len[c] appears on bram_we.
- Rewrites to the same address are counted. Software must not rewrite; no address-coverage tracking is done.
- Rejected write:
  - No bram_we and no count change.
  - err is set; err_code records the first cause only.
  - Precedence when several causes apply: 3 > 1 > 2.
- Writes outside LOAD: silently dropped, no err.
- Simultaneous cfg_start and wr_valid: start wins; the write is dropped without error.
- all_done is the registered AND of load_done. gat_start pulses once per 0 -> 1 transition of all_done, including after a layer-2 reload with mask = weight only.
- Counter arithmetic: LEN_W unsigned, with no wrap, because acceptance stops at len.

Decomposition:
- Shared package gat_pkg: state enum (IDLE, LOAD, DONE), error-code constants, and channel index constants CH_H_DATA = 0, CH_NODE_INFO = 1, CH_WGT = 2.
- One sub-module, gat_load_ch_cnt, instantiated NUM_CH times. Per channel it holds:
  - the length register and counter
  - the done flag
  - the accept decode

Test Plan:
- Basic load: start with mask = 3'b111, len = {2, 3, 4}; write ch0 at byte 0x0 and 0x4, ch1 at 0x0–0x8, ch2 at 0x0–0xC.
  - Expect bram_addr 0,1 / 0,1,2 / 0..3, each one cycle after its write.
  - Expect load_done bits to rise on the final writes, all_done next cycle, and a single gat_start pulse.
- Out of range: len[2] = 4, write ch2 at byte 0x10 -> no bram_we, err = 1, err_code = 1, counter unchanged.
- Bad or masked channel: wr_ch = 3 -> err_code = 3. Then, after a fresh start, write to a masked channel -> err_code = 2.
- Layer-2 reload: after DONE, start with mask = 3'b100, len[2] = 2.
  - load_done drops to 3'b011; after 2 weight writes it returns to 3'b111 and gat_start pulses again.
- Simultaneous events:
  - cfg_start with wr_valid -> write dropped, err = 0.
  - A burst of 5 consecutive writes to ch0 (len = 5) produces 5 consecutive bram_we cycles.
- Reset mid-load: assert rst after 2 of 4 writes -> all outputs return to 0 next cycle; a later start plus 4 writes completes normally.
